hyperbus_burst_ctrl: RTL and testbench

HYPERBUS_BURST_CTRL -- requirements
Module: hyperbus_burst_ctrl
Interface
REQ-001 Parameter WIDTH, default 8: HyperBus DQ width; host data words are 2*WIDTH bits (one DDR clock, rise then fall).
REQ-002 Parameter TACC_COUNT, default 7: initial access latency in clk cycles (1x).
REQ-003 Parameter MAX_BURST, default 16: maximum burst length in 2*WIDTH words; LW = clog2(MAX_BURST+1).
REQ-004 Parameter TRWR, default 3: CS# high recovery cycles between transactions, >=1.
REQ-005 Parameter TIMEOUT, default 64: read cycles allowed without a valid beat before abort; TW = clog2(TIMEOUT+1).
REQ-006 Clock is clk; reset is rst, synchronous, active-high.
REQ-007 cmd_valid  in  1  transaction request.
REQ-008 cmd_ready  out  1  controller accepts request this cycle.
REQ-009 cmd_we  in  1  1 = write, 0 = read.
REQ-010 cmd_reg  in  1  1 = register space, 0 = memory space.
REQ-011 cmd_adr  in  32  word address.
REQ-012 cmd_len  in  LW  burst length in words, legal 1..MAX_BURST.
REQ-013 wdata  in  2*WIDTH  write word; [2*WIDTH-1:WIDTH] = rising-edge byte lane.
REQ-014 wmask  in  2  byte enables for wdata, 1 = write byte; [1] = rising lane.
REQ-015 wdata_valid  in  1  wdata/wmask valid.
REQ-016 wdata_ready  out  1  wdata consumed when wdata_valid and wdata_ready both high.
REQ-017 rdata  out  2*WIDTH  read word, same lane order as wdata.
REQ-018 rdata_valid  out  1  rdata valid, one-cycle qualifier per word.
REQ-019 done  out  1  one-cycle pulse, transaction completed normally.
REQ-020 error  out  1  one-cycle pulse, read timeout abort or illegal cmd_len.
REQ-021 hb_csn  out  1  HyperBus CS#, active low.
REQ-022 hb_clk_en  out  1  gate enable for the phase-shifted HyperBus clock.
REQ-023 hb_dq_o  out  2*WIDTH  DDR output word to the IO DDR cell.
REQ-024 hb_dq_oe  out  1  DQ output enable.
REQ-025 hb_rwds_o  out  2  RWDS output pair (write mask, 1 = byte masked).
REQ-026 hb_rwds_oe  out  1  RWDS output enable.
REQ-027 hb_dq_i  in  2*WIDTH  DDR input word from the IO DDR cell.
REQ-028 hb_rwds_i  in  2  RWDS input pair sampled by the IO DDR cell.
Function
REQ-029 States IDLE, CMD, LATENCY, WRITE, READ, RECOVER; one-hot encoding; unreachable encodings return to IDLE.
REQ-030 cmd_ready = 1 only in IDLE; on cmd_valid&cmd_ready, latch command and build 48-bit CA: [47]=~cmd_we, [46]=cmd_reg, [45]=1 (linear burst), [44:16]=cmd_adr[31:3], [15:3]=0, [2:0]=cmd_adr[2:0]; next state CMD.
REQ-031 cmd_len of 0 or >MAX_BURST: no bus activity, error pulse next cycle, stay IDLE.
REQ-032 CMD lasts exactly 3 cycles driving CA[47:32], CA[31:16], CA[15:0] on hb_dq_o with hb_dq_oe=1.
REQ-033 hb_rwds_i[0] sampled on the third CMD cycle: 1 selects 2*TACC_COUNT latency cycles, 0 selects TACC_COUNT.
REQ-034 Register-space write (cmd_reg=1, cmd_we=1): LATENCY skipped, CMD goes directly to WRITE.
REQ-035 LATENCY: hb_dq_oe=0, hb_rwds_oe=0; exits after exactly the selected count to WRITE (cmd_we) or READ.
REQ-036 WRITE: hb_dq_oe=hb_rwds_oe=1, wdata_ready=1; valid beat drives hb_dq_o=wdata, hb_rwds_o=~wmask, decrements remaining count.
REQ-037 WRITE with wdata_valid=0: drive hb_rwds_o=2'b11 (fully masked beat), no count decrement; burst extends until cmd_len beats consumed.
REQ-038 Register write ignores wmask (hb_rwds_o=2'b00) and completes after 1 beat regardless of cmd_len.
REQ-039 READ: outputs tri-stated; hb_rwds_i != 2'b00 captures hb_dq_i to rdata with rdata_valid=1 next cycle, decrements remaining count, reloads timeout counter to TIMEOUT.
REQ-040 READ timeout counter reaching 0 without beat: error pulse, go RECOVER, no done.
REQ-041 Last beat in WRITE/READ: done pulse, go RECOVER; RECOVER holds hb_csn=1 for TRWR cycles then IDLE.
REQ-042 hb_csn=0 and hb_clk_en=1 exactly in CMD, LATENCY, WRITE, READ.
Reset
REQ-043 rst forces IDLE mid-transaction with no done/error; reset values: cmd_ready=1 after first post-reset cycle, hb_csn=1, hb_clk_en=0, hb_dq_oe=0, hb_rwds_oe=0, wdata_ready=0, rdata_valid=0, done=0, error=0, hb_dq_o=0, hb_rwds_o=0, rdata=0.
Verification
REQ-044 Read adr=0x100, len=4, hb_rwds_i[0]=0 in CMD -> CA words 0xA000,0x0020,0x0000; 7 latency cycles; 4 rdata_valid; done; hb_csn high 3 cycles.
REQ-045 Write len=2, hb_rwds_i[0]=1 in CMD, wmask=2'b01 on beat 2 -> 14 latency cycles; hb_rwds_o=2'b00 then 2'b10; done.
REQ-046 Write len=3 with wdata_valid low one cycle mid-burst -> one hb_rwds_o=2'b11 beat, 4 WRITE cycles total, done.
REQ-047 Register write cmd_reg=1 -> CMD directly followed by one WRITE beat, no LATENCY, done.
REQ-048 Read with hb_rwds_i held 2'b00 -> error pulse after TIMEOUT READ cycles, RECOVER, IDLE; rst asserted mid-WRITE -> IDLE next cycle, hb_csn=1.

---
 rtl/hyperbus_burst_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_hyperbus_burst_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_burst_ctrl.sv
// rtl/hyperbus_burst_ctrl.sv - HyperBus burst transaction controller (CA phase, latency, DDR write/read bursts, recovery)
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   cmd_valid/cmd_ready           request handshake (ready only while idle)
//   cmd_we, cmd_reg, cmd_adr,     direction, address space, word address,
//   cmd_len                       burst length in 2*WIDTH words (1..MAX_BURST)
//   wdata, wmask, wdata_valid,    write word stream; wdata_ready high for the whole
//   wdata_ready                   WRITE phase
//   rdata, rdata_valid            read words, one-cycle qualifier per word
//   done, error                   one-cycle completion / abort pulses
//   hb_csn, hb_clk_en             chip select and HyperBus clock gate
//   hb_dq_o/oe, hb_rwds_o/oe      DDR output word, RWDS mask pair and their enables
//   hb_dq_i, hb_rwds_i            DDR input word and sampled RWDS pair
`timescale 1ns/1ps
module hyperbus_burst_ctrl #(
    parameter int WIDTH      = 8,
    parameter int TACC_COUNT = 7,
    parameter int MAX_BURST  = 16,
    parameter int TRWR       = 3,
    parameter int TIMEOUT    = 64,
    localparam int LW        = $clog2(MAX_BURST + 1),
    localparam int TW        = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic                 cmd_reg,
    input  logic [31:0]          cmd_adr,
    input  logic [LW-1:0]        cmd_len,
    input  logic [2*WIDTH-1:0]   wdata,
    input  logic [1:0]           wmask,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    output logic [2*WIDTH-1:0]   rdata,
    output logic                 rdata_valid,
    output logic                 done,
    output logic                 error,
    output logic                 hb_csn,
    output logic                 hb_clk_en,
    output logic [2*WIDTH-1:0]   hb_dq_o,
    output logic                 hb_dq_oe,
    output logic [1:0]           hb_rwds_o,
    output logic                 hb_rwds_oe,
    input  logic [2*WIDTH-1:0]   hb_dq_i,
    input  logic [1:0]           hb_rwds_i
);

    localparam int DW   = 2 * WIDTH;
    localparam int LATW = $clog2(2 * TACC_COUNT + 1);
    // Recovery counter holds TRWR-1 down to 0.
    localparam int RCW  = (TRWR > 1) ? $clog2(TRWR) : 1;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_CMD     = 6'b000010,
        S_LATENCY = 6'b000100,
        S_WRITE   = 6'b001000,
        S_READ    = 6'b010000,
        S_RECOVER = 6'b100000
    } state_t;

    state_t          state_q, state_d;
    logic [47:0]     ca_q, ca_d;
    logic            we_q, we_d;
    logic            reg_q, reg_d;
    logic [1:0]      cmd_cnt_q, cmd_cnt_d;
    logic [LATW-1:0] lat_cnt_q, lat_cnt_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [TW-1:0]   to_q, to_d;
    logic [RCW-1:0]  rec_cnt_q, rec_cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rdata_valid_q, rdata_valid_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [15:0]     ca_word;

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign error       = error_q;

    always_comb begin
        state_d       = state_q;
        ca_d          = ca_q;
        we_d          = we_q;
        reg_d         = reg_q;
        cmd_cnt_d     = cmd_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        rem_d         = rem_q;
        to_d          = to_q;
        rec_cnt_d     = rec_cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        error_d       = 1'b0;
        ca_word       = 16'h0000;
        cmd_ready     = 1'b0;
        wdata_ready   = 1'b0;
        hb_csn        = 1'b1;
        hb_clk_en     = 1'b0;
        hb_dq_o       = '0;
        hb_dq_oe      = 1'b0;
        hb_rwds_o     = 2'b00;
        hb_rwds_oe    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if ((cmd_len == '0) || (cmd_len > LW'(MAX_BURST))) begin
                        error_d = 1'b1;
                    end else begin
                        ca_d      = {~cmd_we, cmd_reg, 1'b1, cmd_adr[31:3], 13'b0, cmd_adr[2:0]};
                        we_d      = cmd_we;
                        reg_d     = cmd_reg;
                        // Register writes carry exactly one data word.
                        rem_d     = (cmd_we && cmd_reg) ? LW'(1) : cmd_len;
                        cmd_cnt_d = 2'd0;
                        state_d   = S_CMD;
                    end
                end
            end
            S_CMD: begin
                hb_csn    = 1'b0;
                hb_clk_en = 1'b1;
                hb_dq_oe  = 1'b1;
                case (cmd_cnt_q)
                    2'd0:    ca_word = ca_q[47:32];
                    2'd1:    ca_word = ca_q[31:16];
                    default: ca_word = ca_q[15:0];
                endcase
                hb_dq_o   = DW'(ca_word);
                cmd_cnt_d = cmd_cnt_q + 2'd1;
                if (cmd_cnt_q == 2'd2) begin
                    // Device signals doubled latency on RWDS during the CA phase.
                    lat_cnt_d = hb_rwds_i[0] ? LATW'(2 * TACC_COUNT) : LATW'(TACC_COUNT);
                    to_d      = TW'(TIMEOUT);
                    state_d   = (we_q && reg_q) ? S_WRITE : S_LATENCY;
                end
            end
            S_LATENCY: begin
                hb_csn    = 1'b0;
                hb_clk_en = 1'b1;
                lat_cnt_d = lat_cnt_q - LATW'(1);
                if (lat_cnt_q <= LATW'(1)) begin
                    state_d = we_q ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                hb_csn      = 1'b0;
                hb_clk_en   = 1'b1;
                hb_dq_oe    = 1'b1;
                hb_rwds_oe  = 1'b1;
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    hb_dq_o   = wdata;
                    hb_rwds_o = reg_q ? 2'b00 : ~wmask;
                    rem_d     = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        done_d    = 1'b1;
                        rec_cnt_d = RCW'(TRWR - 1);
                        state_d   = S_RECOVER;
                    end
                end else begin
                    // No data available: emit a fully masked filler beat.
                    hb_rwds_o = 2'b11;
                end
            end
            S_READ: begin
                hb_csn    = 1'b0;
                hb_clk_en = 1'b1;
                if (hb_rwds_i != 2'b00) begin
                    rdata_d       = hb_dq_i;
                    rdata_valid_d = 1'b1;
                    rem_d         = rem_q - LW'(1);
                    to_d          = TW'(TIMEOUT);
                    if (rem_q == LW'(1)) begin
                        done_d    = 1'b1;
                        rec_cnt_d = RCW'(TRWR - 1);
                        state_d   = S_RECOVER;
                    end
                end else if (to_q <= TW'(1)) begin
                    error_d   = 1'b1;
                    rec_cnt_d = RCW'(TRWR - 1);
                    state_d   = S_RECOVER;
                end else begin
                    to_d = to_q - TW'(1);
                end
            end
            S_RECOVER: begin
                rec_cnt_d = rec_cnt_q - RCW'(1);
                if (rec_cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ca_q          <= '0;
            we_q          <= 1'b0;
            reg_q         <= 1'b0;
            cmd_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            rem_q         <= '0;
            to_q          <= '0;
            rec_cnt_q     <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ca_q          <= ca_d;
            we_q          <= we_d;
            reg_q         <= reg_d;
            cmd_cnt_q     <= cmd_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            rem_q         <= rem_d;
            to_q          <= to_d;
            rec_cnt_q     <= rec_cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// tb/tb_hyperbus_burst_ctrl.sv - directed vector bench for hyperbus_burst_ctrl
`timescale 1ns/1ps
module tb_hyperbus_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic        cmd_reg = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [4:0]  cmd_len = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  wmask = 2'b11;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        error;
    logic        hb_csn;
    logic        hb_clk_en;
    logic [15:0] hb_dq_o;
    logic        hb_dq_oe;
    logic [1:0]  hb_rwds_o;
    logic        hb_rwds_oe;
    logic [15:0] hb_dq_i = '0;
    logic [1:0]  hb_rwds_i = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    hyperbus_burst_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_reg     (cmd_reg),
        .cmd_adr     (cmd_adr),
        .cmd_len     (cmd_len),
        .wdata       (wdata),
        .wmask       (wmask),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .error       (error),
        .hb_csn      (hb_csn),
        .hb_clk_en   (hb_clk_en),
        .hb_dq_o     (hb_dq_o),
        .hb_dq_oe    (hb_dq_oe),
        .hb_rwds_o   (hb_rwds_o),
        .hb_rwds_oe  (hb_rwds_oe),
        .hb_dq_i     (hb_dq_i),
        .hb_rwds_i   (hb_rwds_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        rg;
        logic [31:0] adr;
        logic [4:0]  len;
        logic        lat;
        logic [15:0] ca0;
        logic [15:0] ca1;
        logic [15:0] ca2;
        int          n_lat;
        int          n_beats;
        logic        bad;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic cyc_begin();
        @(negedge clk);
    endtask

    task automatic start(input logic we, input logic rg, input logic [31:0] adr, input logic [4:0] len,
                         input logic lat, input logic chk_ca, input logic [15:0] ca0,
                         input logic [15:0] ca1, input logic [15:0] ca2);
        cyc_begin();
        cmd_valid = 1'b1; cmd_we = we; cmd_reg = rg; cmd_adr = adr; cmd_len = len;
        #1 check("cmd_ready_idle", cmd_ready, 1'b1);
        cyc_begin();
        cmd_valid = 1'b0; hb_rwds_i = 2'b00;
        #1 check("cmd0_ctl", {hb_csn, hb_dq_oe, hb_clk_en, cmd_ready}, 4'b0110);
        if (chk_ca) check("ca0", hb_dq_o, ca0);
        cyc_begin();
        #1 check("cmd1_ctl", {hb_csn, hb_dq_oe, hb_clk_en}, 3'b011);
        if (chk_ca) check("ca1", hb_dq_o, ca1);
        cyc_begin();
        hb_rwds_i = {1'b0, lat};
        #1 check("cmd2_ctl", {hb_csn, hb_dq_oe, hb_clk_en}, 3'b011);
        if (chk_ca) check("ca2", hb_dq_o, ca2);
    endtask

    // During latency a read may see stray RWDS activity; it must be ignored.
    task automatic skip_lat(input int n, input logic poison);
        for (int k = 0; k < n; k++) begin
            cyc_begin();
            hb_rwds_i = poison ? 2'b11 : 2'b00;
            hb_dq_i   = 16'hDEAD;
            #1 check("lat_ctl", {hb_csn, hb_clk_en, hb_dq_oe, hb_rwds_oe, wdata_ready, rdata_valid},
                     6'b010000);
        end
    endtask

    task automatic recover_tail();
        for (int k = 0; k < 2; k++) begin
            cyc_begin();
            #1 check("recover_ctl", {hb_csn, cmd_ready, hb_clk_en}, 3'b100);
        end
        cyc_begin();
        #1 check("back_idle", {hb_csn, cmd_ready}, 2'b11);
    endtask

    task automatic write_beat(input string name, input logic v, input logic [15:0] d,
                              input logic [1:0] m, input logic [1:0] exp_rwds);
        cyc_begin();
        wdata_valid = v; wdata = d; wmask = m;
        #1 check({name, "_ctl"}, {wdata_ready, hb_dq_oe, hb_rwds_oe, hb_csn, done}, 5'b11100);
        check({name, "_rwds"}, hb_rwds_o, exp_rwds);
        if (v) check({name, "_dq"}, hb_dq_o, d);
    endtask

    initial begin
        logic [15:0] pat;
        logic [15:0] last;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100,  5'd4, 1'b0, 16'hA000, 16'h0020, 16'h0000,  7,  4, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h1234_5677,  5'd2, 1'b1, 16'h2246, 16'h8ACE, 16'h0007, 14,  2, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0001,  5'd1, 1'b1, 16'hE000, 16'h0000, 16'h0001, 14,  1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_0800,  5'd5, 1'b0, 16'h6000, 16'h0100, 16'h0000,  0,  1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'hFFFF_FFF8, 5'd16, 1'b0, 16'hBFFF, 16'hFFFF, 16'h0000,  7, 16, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0040,  5'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000,  0,  0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0040, 5'd17, 1'b0, 16'h0000, 16'h0000, 16'h0000,  0,  0, 1'b1};

        repeat (3) @(posedge clk);
        #1 check("reset_outs",
                 {hb_csn, hb_clk_en, hb_dq_oe, hb_rwds_oe, wdata_ready, rdata_valid, done, error},
                 8'b10000000);
        check("reset_data", {hb_dq_o, hb_rwds_o, rdata}, 34'h0);
        cyc_begin();
        rst = 1'b0;
        #1 check("reset_ready", cmd_ready, 1'b1);

        for (int t = 0; t < 7; t++) begin
            if (tbl[t].bad) begin
                cyc_begin();
                cmd_valid = 1'b1; cmd_we = tbl[t].we; cmd_reg = 1'b0;
                cmd_adr = tbl[t].adr; cmd_len = tbl[t].len;
                #1 check("bad_ready", cmd_ready, 1'b1);
                cyc_begin();
                cmd_valid = 1'b0;
                #1 check("bad_err", {error, done, hb_csn, hb_dq_oe, cmd_ready}, 5'b10101);
                cyc_begin();
                #1 check("bad_err_once", {error, hb_csn}, 2'b01);
            end else begin
                start(tbl[t].we, tbl[t].rg, tbl[t].adr, tbl[t].len, tbl[t].lat, 1'b1,
                      tbl[t].ca0, tbl[t].ca1, tbl[t].ca2);
                skip_lat(tbl[t].n_lat, ~tbl[t].we);
                last = '0;
                for (int i = 0; i < tbl[t].n_beats; i++) begin
                    pat = 16'(32'hA500 + t * 32 + i);
                    if (tbl[t].we) begin
                        write_beat("wr_beat", 1'b1, pat, 2'b01, tbl[t].rg ? 2'b00 : 2'b10);
                    end else begin
                        cyc_begin();
                        hb_rwds_i = 2'b11; hb_dq_i = pat;
                        #1 check("rd_ctl", {hb_csn, hb_dq_oe, hb_rwds_oe, done}, 4'b0000);
                        check("rd_valid", rdata_valid, (i > 0) ? 1'b1 : 1'b0);
                        if (i > 0) check("rd_data", rdata, last);
                    end
                    last = pat;
                end
                cyc_begin();
                wdata_valid = 1'b0; hb_rwds_i = 2'b00;
                #1 check("txn_done", {done, error, hb_csn, hb_clk_en}, 4'b1010);
                if (!tbl[t].we) begin
                    check("rd_last_valid", rdata_valid, 1'b1);
                    check("rd_last_data", rdata, last);
                end
                recover_tail();
            end
        end

        // Doubled latency, byte mask on the second beat.
        start(1'b1, 1'b0, 32'h0000_0300, 5'd2, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        skip_lat(14, 1'b0);
        write_beat("mask_b1", 1'b1, 16'h1111, 2'b11, 2'b00);
        write_beat("mask_b2", 1'b1, 16'h2222, 2'b01, 2'b10);
        cyc_begin();
        wdata_valid = 1'b0;
        #1 check("mask_done", {done, error, hb_csn}, 3'b101);
        recover_tail();

        // Write stall mid-burst inserts one fully masked beat.
        start(1'b1, 1'b0, 32'h0000_0200, 5'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        skip_lat(7, 1'b0);
        write_beat("stall_b1", 1'b1, 16'h3333, 2'b11, 2'b00);
        write_beat("stall_gap", 1'b0, 16'h0000, 2'b11, 2'b11);
        write_beat("stall_b2", 1'b1, 16'h4444, 2'b11, 2'b00);
        write_beat("stall_b3", 1'b1, 16'h5555, 2'b11, 2'b00);
        cyc_begin();
        wdata_valid = 1'b0;
        #1 check("stall_done", {done, error, hb_csn}, 3'b101);
        recover_tail();

        // Read with no RWDS activity aborts after TIMEOUT read cycles.
        start(1'b0, 1'b0, 32'h0000_0040, 5'd2, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        skip_lat(7, 1'b1);
        for (int k = 0; k < 64; k++) begin
            cyc_begin();
            hb_rwds_i = 2'b00;
            #1 check("to_wait", {hb_csn, error, done, rdata_valid}, 4'b0000);
        end
        cyc_begin();
        #1 check("to_abort", {error, done, hb_csn, hb_clk_en}, 4'b1010);
        recover_tail();

        // Reset during a write burst returns straight to idle.
        start(1'b1, 1'b0, 32'h0000_0080, 5'd4, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        skip_lat(7, 1'b0);
        write_beat("rst_b1", 1'b1, 16'h6666, 2'b11, 2'b00);
        cyc_begin();
        rst = 1'b1;
        cyc_begin();
        rst = 1'b0; wdata_valid = 1'b0;
        #1 check("rst_mid", {hb_csn, hb_clk_en, wdata_ready, hb_dq_oe, hb_rwds_oe, done, error, cmd_ready},
                 8'b10000001);
        cyc_begin();
        #1 check("rst_after", {hb_csn, done, error}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
